// File: rtl/booth_multiplier_seq.sv
// Iterative radix-2 Booth multiplier: one Booth step per clock, signed or
// unsigned operands selected per operation, valid/ready on both sides.
module booth_multiplier_seq #(
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     multiplicand,
  input  logic [WIDTH-1:0]     multiplier,
  input  logic                 is_signed,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   product,
  output logic                 busy,
  output logic [1:0]           state_dbg
);

  // Handshakes: a transfer happens on a rising edge where valid and ready are
  // both high; valid never depends on ready, and a pending result (out_valid)
  // keeps product stable until it is taken.

  localparam int N  = WIDTH + 1;
  localparam int PW = 2 * N + 1;
  localparam int CW = $clog2(N + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t               state_q;
  logic [PW-1:0]        p_q;
  logic [N-1:0]         m_q;
  logic [CW-1:0]        cnt_q;
  logic [2*WIDTH-1:0]   product_q;
  logic                 in_ready_q;
  logic                 out_valid_q;
  logic                 busy_q;

  logic [N-1:0]         a_ext;
  logic [N-1:0]         b_ext;
  logic [N-1:0]         upper_d;
  logic [PW-1:0]        p_d;

  // Extra top bit gives unsigned operands a zero sign so Booth recoding holds.
  always_comb begin
    a_ext = {is_signed & multiplicand[WIDTH-1], multiplicand};
    b_ext = {is_signed & multiplier[WIDTH-1], multiplier};
  end

  always_comb begin
    upper_d = p_q[PW-1 -: N];
    case (p_q[1:0])
      2'b01:   upper_d = p_q[PW-1 -: N] + m_q;
      2'b10:   upper_d = p_q[PW-1 -: N] - m_q;
      default: upper_d = p_q[PW-1 -: N];
    endcase
    p_d = {upper_d[N-1], upper_d, p_q[N:1]};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      p_q         <= '0;
      m_q         <= '0;
      cnt_q       <= '0;
      product_q   <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (in_valid) begin
            p_q        <= {{N{1'b0}}, b_ext, 1'b0};
            m_q        <= a_ext;
            cnt_q      <= CW'(N);
            state_q    <= S_RUN;
            in_ready_q <= 1'b0;
            busy_q     <= 1'b1;
          end
        end
        S_RUN: begin
          p_q   <= p_d;
          cnt_q <= cnt_q - CW'(1);
          if (cnt_q == CW'(1)) begin
            state_q     <= S_DONE;
            busy_q      <= 1'b0;
            out_valid_q <= 1'b1;
            product_q   <= p_d[2*WIDTH:1];
          end
        end
        S_DONE: begin
          if (out_ready) begin
            state_q     <= S_IDLE;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
          end
        end
        default: begin
          state_q     <= S_IDLE;
          out_valid_q <= 1'b0;
          in_ready_q  <= 1'b1;
          busy_q      <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign busy      = busy_q;
  assign product   = product_q;
  assign state_dbg = state_q;

endmodule

// File: tb/tb_booth_multiplier_seq.sv
// Bench for booth_multiplier_seq: WIDTH=8 directed/random/handshake tests,
// WIDTH=16 random sweep and WIDTH=2 exhaustive sweep against plain arithmetic.
module tb_booth_multiplier_seq;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;

  logic        in_valid8, in_ready8, is_signed8, out_valid8, out_ready8, busy8;
  logic [7:0]  a8, b8;
  logic [15:0] prod8;
  logic [1:0]  st8;

  logic        in_valid16, in_ready16, is_signed16, out_valid16, out_ready16, busy16;
  logic [15:0] a16, b16;
  logic [31:0] prod16;
  logic [1:0]  st16;

  logic        in_valid2, in_ready2, is_signed2, out_valid2, out_ready2, busy2;
  logic [1:0]  a2, b2;
  logic [3:0]  prod2;
  logic [1:0]  st2;

  booth_multiplier_seq #(.WIDTH(8)) u8 (
    .clk(clk), .rst(rst), .in_valid(in_valid8), .in_ready(in_ready8),
    .multiplicand(a8), .multiplier(b8), .is_signed(is_signed8),
    .out_valid(out_valid8), .out_ready(out_ready8), .product(prod8),
    .busy(busy8), .state_dbg(st8));

  booth_multiplier_seq #(.WIDTH(16)) u16 (
    .clk(clk), .rst(rst), .in_valid(in_valid16), .in_ready(in_ready16),
    .multiplicand(a16), .multiplier(b16), .is_signed(is_signed16),
    .out_valid(out_valid16), .out_ready(out_ready16), .product(prod16),
    .busy(busy16), .state_dbg(st16));

  booth_multiplier_seq #(.WIDTH(2)) u2 (
    .clk(clk), .rst(rst), .in_valid(in_valid2), .in_ready(in_ready2),
    .multiplicand(a2), .multiplier(b2), .is_signed(is_signed2),
    .out_valid(out_valid2), .out_ready(out_ready2), .product(prod2),
    .busy(busy2), .state_dbg(st2));

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  logic [15:0] exp_q[$];
  int rise_cyc[$];
  logic ov8_prev = 1'b0;

  typedef struct {
    logic [7:0]  a;
    logic [7:0]  b;
    logic        s;
    logic [15:0] exp;
  } vec_t;
  vec_t vecs[9];

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  // Reference: extend each operand by its mode and multiply as integers.
  function automatic longint ref_mul(input longint a, input longint b, input int w, input bit s);
    longint ea, eb;
    ea = (s && a[w-1]) ? a - (longint'(1) << w) : a;
    eb = (s && b[w-1]) ? b - (longint'(1) << w) : b;
    return ea * eb;
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard for the WIDTH=8 instance: compare on every output transfer.
  always @(negedge clk) begin
    if (!rst) begin
      if (out_valid8 && !ov8_prev) rise_cyc.push_back(cyc);
      if (out_valid8 && out_ready8) begin
        if (exp_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL sb_unexpected: got 0x%0h with no expected value queued", prod8);
        end else begin
          check("sb_product8", {48'd0, prod8}, {48'd0, exp_q.pop_front()});
        end
      end
    end
    ov8_prev = out_valid8;
  end

  task automatic run8(input logic [7:0] a, input logic [7:0] b, input logic s, input logic [15:0] exp);
    int t;
    t = 0;
    while (!in_ready8 && t < 100) begin tick; t++; end
    check("accept_wait8", in_ready8, 1);
    a8 = a; b8 = b; is_signed8 = s; in_valid8 = 1'b1;
    exp_q.push_back(exp);
    tick;
    in_valid8 = 1'b0;
    a8 = 8'($urandom); b8 = 8'($urandom); is_signed8 = 1'($urandom);
    t = 0;
    while (!out_valid8 && t < 100) begin tick; t++; end
    check("latency8", t, 9);
  endtask

  task automatic run16(input logic [15:0] a, input logic [15:0] b, input logic s);
    int t;
    longint r;
    logic [31:0] exp;
    r = ref_mul(longint'(a), longint'(b), 16, s);
    exp = r[31:0];
    t = 0;
    while (!in_ready16 && t < 100) begin tick; t++; end
    a16 = a; b16 = b; is_signed16 = s; in_valid16 = 1'b1;
    tick;
    in_valid16 = 1'b0;
    a16 = 16'($urandom);
    t = 0;
    while (!out_valid16 && t < 100) begin tick; t++; end
    check("w16_product", {32'd0, prod16}, {32'd0, exp});
  endtask

  task automatic run2(input logic [1:0] a, input logic [1:0] b, input logic s);
    int t;
    longint r;
    logic [3:0] exp;
    r = ref_mul(longint'(a), longint'(b), 2, s);
    exp = r[3:0];
    t = 0;
    while (!in_ready2 && t < 100) begin tick; t++; end
    a2 = a; b2 = b; is_signed2 = s; in_valid2 = 1'b1;
    tick;
    in_valid2 = 1'b0;
    t = 0;
    while (!out_valid2 && t < 100) begin tick; t++; end
    check("w2_product", {60'd0, prod2}, {60'd0, exp});
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int t, seen;
    logic [15:0] held;
    logic [7:0] ra, rb;
    logic rs;
    longint r;
    logic [7:0]  b2b_a[4];
    logic [7:0]  b2b_b[4];
    logic [15:0] b2b_e[4];

    vecs[0] = '{8'hF9, 8'h06, 1'b1, 16'hFFD6};
    vecs[1] = '{8'h80, 8'h80, 1'b1, 16'h4000};
    vecs[2] = '{8'h7F, 8'h80, 1'b1, 16'hC080};
    vecs[3] = '{8'hFF, 8'hFF, 1'b0, 16'hFE01};
    vecs[4] = '{8'h80, 8'h02, 1'b0, 16'h0100};
    vecs[5] = '{8'hFF, 8'hFF, 1'b1, 16'h0001};
    vecs[6] = '{8'h80, 8'h02, 1'b1, 16'hFF00};
    vecs[7] = '{8'h00, 8'h80, 1'b1, 16'h0000};
    vecs[8] = '{8'h7F, 8'h80, 1'b0, 16'h3F80};

    rst = 1'b1;
    in_valid8 = 0; a8 = 0; b8 = 0; is_signed8 = 0; out_ready8 = 1;
    in_valid16 = 0; a16 = 0; b16 = 0; is_signed16 = 0; out_ready16 = 1;
    in_valid2 = 0; a2 = 0; b2 = 0; is_signed2 = 0; out_ready2 = 1;
    repeat (3) tick;
    rst = 1'b0;
    tick;
    check("reset_in_ready", in_ready8, 1);
    check("reset_out_valid", out_valid8, 0);
    check("reset_busy", busy8, 0);
    check("reset_product", {48'd0, prod8}, 64'd0);

    for (int i = 0; i < 200; i++) begin
      ra = 8'($urandom); rb = 8'($urandom); rs = 1'($urandom_range(0, 1));
      r = ref_mul(longint'(ra), longint'(rb), 8, rs);
      run8(ra, rb, rs, r[15:0]);
    end

    for (int i = 0; i < 9; i++) run8(vecs[i].a, vecs[i].b, vecs[i].s, vecs[i].exp);
    tick;

    // Reset two cycles into an operation: result must be dropped.
    a8 = 8'd25; b8 = 8'd3; is_signed8 = 1'b0; in_valid8 = 1'b1;
    tick;
    in_valid8 = 1'b0;
    tick;
    tick;
    check("mid_run_busy", busy8, 1);
    rst = 1'b1;
    #1;
    check("rst_mid_in_ready", in_ready8, 1);
    check("rst_mid_out_valid", out_valid8, 0);
    check("rst_mid_busy", busy8, 0);
    check("rst_mid_product", {48'd0, prod8}, 64'd0);
    #1;
    rst = 1'b0;
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      tick;
      if (out_valid8) seen = 1;
    end
    check("rst_no_valid_after", seen, 0);

    // Back-pressure: result held for 20 cycles with inputs poked meanwhile.
    out_ready8 = 1'b0;
    a8 = 8'h9C; b8 = 8'h05; is_signed8 = 1'b1; in_valid8 = 1'b1;
    exp_q.push_back(16'hFE0C);
    tick;
    in_valid8 = 1'b0;
    t = 0;
    while (!out_valid8 && t < 100) begin tick; t++; end
    check("bp_latency", t, 9);
    held = prod8;
    check("bp_value", {48'd0, held}, {48'd0, 16'hFE0C});
    for (int i = 0; i < 20; i++) begin
      in_valid8 = 1'($urandom_range(0, 1));
      a8 = 8'($urandom); b8 = 8'($urandom);
      tick;
      check("bp_product_stable", {48'd0, prod8}, {48'd0, held});
      check("bp_in_ready_low", in_ready8, 0);
      check("bp_out_valid_high", out_valid8, 1);
    end
    in_valid8 = 1'b0;
    out_ready8 = 1'b1;
    tick;
    check("bp_release_out_valid", out_valid8, 0);
    check("bp_release_in_ready", in_ready8, 1);
    check("bp_release_busy", busy8, 0);
    check("bp_product_kept", {48'd0, prod8}, {48'd0, held});

    // Back-to-back stream with in_valid and out_ready held high.
    b2b_a = '{8'd3, 8'hFF, 8'h00, 8'd100};
    b2b_b = '{8'd5, 8'hFF, 8'h80, 8'h9C};
    b2b_e = '{16'd15, 16'd1, 16'd0, 16'hD8F0};
    rise_cyc.delete();
    in_valid8 = 1'b1;
    for (int i = 0; i < 4; i++) begin
      a8 = b2b_a[i]; b8 = b2b_b[i]; is_signed8 = 1'b1;
      t = 0;
      while (!in_ready8 && t < 100) begin tick; t++; end
      check("b2b_accept", in_ready8, 1);
      exp_q.push_back(b2b_e[i]);
      tick;
    end
    in_valid8 = 1'b0;
    t = 0;
    while (rise_cyc.size() < 4 && t < 100) begin tick; t++; end
    tick;
    check("b2b_results", rise_cyc.size(), 4);
    for (int i = 1; i < rise_cyc.size(); i++)
      check("b2b_spacing", rise_cyc[i] - rise_cyc[i-1], 11);

    run16(16'h8000, 16'h8000, 1'b1);
    run16(16'hFFFF, 16'hFFFF, 1'b0);
    run16(16'h7FFF, 16'h8000, 1'b1);
    run16(16'hFFFF, 16'h0001, 1'b1);
    for (int i = 0; i < 1000; i++)
      run16(16'($urandom), 16'($urandom), 1'($urandom_range(0, 1)));

    for (int s = 0; s < 2; s++)
      for (int a = 0; a < 4; a++)
        for (int b = 0; b < 4; b++)
          run2(2'(a), 2'(b), 1'(s));

    tick;
    check("sb_leftover", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/booth_multiplier_seq.md
Name: booth_multiplier_seq

Overview:
- Parametrised, iterative radix-2 Booth multiplier.
- Handles one Booth step per clock, so area is traded for latency.
- Supports signed and unsigned operands, selected per operation.
- Uses a valid/ready handshake on both the operand side and the result side, so it can sit directly between streaming arithmetic stages in the datapath.

Parameters:
- WIDTH, 8, operand width in bits; must be ≥ 2; product width is 2*WIDTH.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- in_valid  input  1  operand pair and mode are valid
- in_ready  output  1  block can accept a new operand pair
- multiplicand  input  WIDTH  operand A
- multiplier  input  WIDTH  operand B
- is_signed  input  1  1 = two's-complement operands, 0 = unsigned operands
- out_valid  output  1  product is valid and held stable
- out_ready  input  1  downstream accepts the product
- product  output  2*WIDTH  A*B, two's-complement if signed, unsigned otherwise
- busy  output  1  an operation is in progress (state RUN)

Behaviour:
- Reset (async, rst=1):
  - state=IDLE, in_ready=1, out_valid=0, busy=0, product=0.
  - Internal accumulator and counter are cleared.
  - A reset during RUN or DONE aborts the operation; the result is lost and no out_valid is produced.
- Internal width N=WIDTH+1. On accept, each operand is extended to N bits:
  - sign-extended if is_signed=1;
  - zero-extended if is_signed=0.
  - This gives unsigned operands a Booth-compatible sign bit.
  - is_signed is sampled only at accept.
- Accumulator P has 2N+1 bits, laid out as {upper N bits, multiplier N bits, guard bit}.
  - Accept loads P={N'b0, B_ext, 1'b0}.
  - Registers M=A_ext and a step count=N.
- States:
  - IDLE: in_ready=1. On a clock edge with in_valid&in_ready → load operands, go to RUN.
  - RUN: in_ready=0, busy=1. Each edge performs one Booth step:
    - P[1:0]=01 → upper += M;
    - P[1:0]=10 → upper -= M;
    - 00 or 11 → no add.
    - Then P is arithmetic-shifted right by 1 and count decrements.
    - The add/subtract is N-bit wraparound in the upper field.
    - On the edge that completes step N → go to DONE. product is registered from P[2N:1] truncated to the low 2*WIDTH bits.
  - DONE: out_valid=1. product holds stable while out_ready=0 (no back-pressure limit). On an edge with out_ready=1 → go to IDLE, out_valid=0.
    - product keeps its last value until the next completion; it is never cleared except by reset.
- Handshake rules:
  - in_ready is 0 in RUN and DONE, so no operand is taken until the result is consumed.
  - Operands do not need to stay stable after the accept edge.
  - in_valid asserted in RUN/DONE is ignored and does not queue.
- Latency and throughput:
  - Accept edge E0 → out_valid observed high after edge E(WIDTH+1).
  - With out_ready held high, the next accept is possible at edge E(WIDTH+3).
  - Minimum issue interval is therefore WIDTH+3 cycles.
- Width rules: the exact product always fits in 2*WIDTH bits.
  - Signed: most-negative × most-negative = 2^(2W-2) < 2^(2W-1).
  - Unsigned: (2^W-1)^2 < 2^(2W).
  - No overflow flag is needed.
- out_valid and out_ready both high on the same edge as an in_valid: no accept occurs on that edge, because in_ready=0 in DONE. The accept happens at the next edge in IDLE.

Test Plan:
- Reset mid-RUN:
  - Accept A=8'd25, B=8'd3, assert rst two cycles later.
  - Outputs immediately show in_ready=1, out_valid=0, busy=0, product=0.
  - No out_valid afterwards until a new accept.
- Signed basics (WIDTH=8, is_signed=1):
  - (-7)×(6) → product=16'hFFD6 (-42);
  - (-128)×(-128) → 16'h4000;
  - (127)×(-128) → 16'hC080.
  - out_valid rises exactly WIDTH+1=9 edges after accept.
- Unsigned mode (is_signed=0):
  - 8'hFF×8'hFF → 16'hFE01;
  - 8'h80×8'h02 → 16'h0100.
  - The same bit patterns with is_signed=1 give 16'h0001 and 16'hFF00.
- Back-pressure:
  - Hold out_ready=0 for 20 cycles after out_valid.
  - product stays stable and in_ready stays 0 throughout.
  - in_valid pulses during this window are not accepted.
  - Raising out_ready → IDLE on the next edge.
- Back-to-back throughput:
  - Keep in_valid and out_ready high and stream 4 operand pairs: 3×5, -1×-1, 0×-128, 100×-100.
  - Products 15, 1, 0, 16'hD8F0, each spaced 11 cycles apart.
- Parametrisation:
  - WIDTH=16 random signed/unsigned sweep (≥1000 vectors) against a reference model.
  - WIDTH=2 exhaustive sweep (all 16 pairs × 2 modes).
